// File: rtl/eth_10g_pause_pkg.sv
// eth_10g_pause_pkg
//   Shared constants, FSM state type and beat-layout helper for the
//   802.3x PAUSE frame generator. The frame body is 60 bytes, carried as
//   eight 64-bit beats with the first byte on [63:56].
package eth_10g_pause_pkg;

  localparam logic [47:0] PAUSE_DA         = 48'h0180C2000001;
  localparam logic [15:0] MAC_CTRL_ETYPE   = 16'h8808;
  localparam logic [15:0] PAUSE_OPCODE     = 16'h0001;
  localparam int          PAUSE_BEATS      = 8;
  localparam logic [2:0]  PAUSE_LAST_BEAT  = 3'(PAUSE_BEATS - 1);
  localparam logic [2:0]  PAUSE_LAST_EMPTY = 3'd4;

  typedef enum logic {
    IDLE,
    SEND
  } pause_state_e;

  // Payload for a given beat index. Beats 3..7 are padding. The last four
  // bytes of beat 7 are don't-care and are driven as zero.
  function automatic logic [63:0] pause_beat(input logic [2:0]  beat,
                                             input logic [47:0] sa,
                                             input logic [15:0] quanta);
    logic [63:0] data;
    data = '0;
    case (beat)
      3'd0:    data = {PAUSE_DA, sa[47:32]};
      3'd1:    data = {sa[31:0], MAC_CTRL_ETYPE, PAUSE_OPCODE};
      3'd2:    data = {quanta, 48'h0};
      default: data = '0;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/eth_10g_pause_frame_gen.sv
// eth_10g_pause_frame_gen
//   Emits XOFF/XON MAC-control PAUSE frame bodies (60 bytes, no CRC) on a
//   64-bit Avalon-ST source (readyLatency 0).
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cfg_enable            0 blocks new frames; a frame in flight completes
//   cfg_src_addr          station MAC address, [47:40] sent first
//   cfg_pause_quanta      quanta value carried in XOFF frames
//   cfg_holdoff           XOFF refresh period in cycles, 0 = no refresh
//   xoff_req              level request, 1 = peer must pause
//   out_*                 Avalon-ST source, all outputs registered
//   busy                  frame in flight
//   frame_sent            one-cycle pulse after the EOP beat is accepted
module eth_10g_pause_frame_gen
  import eth_10g_pause_pkg::*;
#(
  parameter int HOLDOFF_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_enable,
  input  logic [47:0]          cfg_src_addr,
  input  logic [15:0]          cfg_pause_quanta,
  input  logic [HOLDOFF_W-1:0] cfg_holdoff,
  input  logic                 xoff_req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic [1:0]           out_error,
  output logic                 out_startofpacket,
  output logic                 out_endofpacket,
  output logic [2:0]           out_empty,
  output logic                 busy,
  output logic                 frame_sent
);

  pause_state_e         state_q, state_d;
  logic [2:0]           beat_q, beat_d;
  logic                 adv_q, adv_d;
  logic [47:0]          sa_q, sa_d;
  logic [15:0]          quanta_q, quanta_d;
  logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;
  logic                 out_valid_q, out_valid_d;
  logic [63:0]          out_data_q, out_data_d;
  logic                 out_sop_q, out_sop_d;
  logic                 out_eop_q, out_eop_d;
  logic [2:0]           out_empty_q, out_empty_d;
  logic                 frame_sent_q, frame_sent_d;

  logic                 accept;
  logic                 holdoff_expired;
  logic                 start;
  logic                 launch;
  logic [2:0]           beat_nxt;
  logic [15:0]          start_quanta;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    beat_d       = beat_q;
    adv_d        = adv_q;
    sa_d         = sa_q;
    quanta_d     = quanta_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    out_empty_d  = out_empty_q;
    frame_sent_d = 1'b0;
    launch       = 1'b0;
    beat_nxt     = beat_q + 3'd1;
    start_quanta = xoff_req ? cfg_pause_quanta : 16'h0000;
    holdoff_d    = (holdoff_q != '0) ? holdoff_q - HOLDOFF_W'(1) : '0;

    accept = out_valid_q && out_ready;
    // The counter reaches zero at the end of this cycle, so a refresh SOP
    // lands exactly cfg_holdoff+1 cycles after the previous XOFF SOP.
    holdoff_expired = (holdoff_q <= HOLDOFF_W'(1));
    start = cfg_enable &&
            ((xoff_req != adv_q) ||
             (xoff_req && adv_q && (cfg_holdoff != '0) && holdoff_expired));

    case (state_q)
      IDLE: launch = start;
      SEND: begin
        if (accept) begin
          // adv_q already holds this frame's type.
          if (out_sop_q && adv_q) holdoff_d = cfg_holdoff;
          if (beat_q == PAUSE_LAST_BEAT) begin
            frame_sent_d = 1'b1;
            launch       = start;
            state_d      = IDLE;
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            out_sop_d    = 1'b0;
            out_eop_d    = 1'b0;
            out_empty_d  = '0;
          end else begin
            beat_d      = beat_nxt;
            out_data_d  = pause_beat(beat_nxt, sa_q, quanta_q);
            out_sop_d   = 1'b0;
            out_eop_d   = (beat_nxt == PAUSE_LAST_BEAT);
            out_empty_d = (beat_nxt == PAUSE_LAST_BEAT) ? PAUSE_LAST_EMPTY : 3'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Starting a frame overrides the end-of-frame idle values, which gives
    // back-to-back frames with no gap beat.
    if (launch) begin
      state_d     = SEND;
      beat_d      = 3'd0;
      adv_d       = xoff_req;
      sa_d        = cfg_src_addr;
      quanta_d    = start_quanta;
      out_valid_d = 1'b1;
      out_data_d  = pause_beat(3'd0, cfg_src_addr, start_quanta);
      out_sop_d   = 1'b1;
      out_eop_d   = 1'b0;
      out_empty_d = 3'd0;
      if (!xoff_req) holdoff_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      beat_q       <= 3'd0;
      adv_q        <= 1'b0;
      sa_q         <= '0;
      quanta_q     <= '0;
      holdoff_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_empty_q  <= '0;
      frame_sent_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      adv_q        <= adv_d;
      sa_q         <= sa_d;
      quanta_q     <= quanta_d;
      holdoff_q    <= holdoff_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_empty_q  <= out_empty_d;
      frame_sent_q <= frame_sent_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_error         = 2'b00;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_empty         = out_empty_q;
  // A frame is in flight exactly while the source holds valid.
  assign busy              = out_valid_q;
  assign frame_sent        = frame_sent_q;

endmodule

// File: doc/eth_10g_pause_frame_gen.md
# eth_10g_pause_frame_gen

Generates IEEE 802.3x MAC-control PAUSE frames (XOFF/XON) as 64-bit Avalon-ST packets. It drives the flow-control input (in0) of the TX flow-control/user-frame multiplexer, which arbitrates them against user traffic ahead of the MAC TX datapath. CRC and preamble are appended downstream, so the block emits the 60-byte frame body only.

## Interface
Parameters:
- HOLDOFF_W, 16, width of the refresh holdoff counter and of cfg_holdoff.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- cfg_enable  in  1  0 blocks new frames from starting; a frame already in flight completes.
- cfg_src_addr  in  48  station MAC address; [47:40] is transmitted first.
- cfg_pause_quanta  in  16  quanta value carried in XOFF frames.
- cfg_holdoff  in  HOLDOFF_W  XOFF refresh period in clk cycles; 0 disables refresh.
- xoff_req  in  1  level; 1 = peer must pause.
- out_valid  out  1  Avalon-ST valid.
- out_ready  in  1  Avalon-ST ready; readyLatency 0.
- out_data  out  64  payload; first byte on [63:56].
- out_error  out  2  tied to 0.
- out_startofpacket  out  1  SOP.
- out_endofpacket  out  1  EOP.
- out_empty  out  3  empty bytes; nonzero only on EOP.
- busy  out  1  frame in flight.
- frame_sent  out  1  one-cycle pulse when the EOP beat is accepted.

## Operation
- State register `adv` holds the last advertised state (0 = XON, 1 = XOFF). Reset value is 0.
- States:
  - IDLE: start a frame when cfg_enable=1 and either (a) xoff_req != adv, or (b) xoff_req=1, adv=1, cfg_holdoff!=0 and the holdoff counter is 0.
  - SEND: drive beats 0–7 using beat counter `beat` (3-bit).
- Frame type is decided at start from xoff_req:
  - XOFF carries the latched cfg_pause_quanta.
  - XON carries quanta 0x0000.
  - adv is updated to the frame type at start.
- cfg_src_addr and the quanta value are latched at start. They stay stable for the whole frame.
- Beat layout, byte order first to last:
  - beat0: 01 80 C2 00 00 01, SA0, SA1. SOP=1.
  - beat1: SA2..SA5, 88 08, 00 01.
  - beat2: Qhi, Qlo, six bytes of 00.
  - beats 3–6: all zero.
  - beat7: 00 00 00 00, then don't-care bytes driven 0. EOP=1, empty=4.
  - Total length: 60 bytes.
- Handshake:
  - A beat advances only when out_valid && out_ready.
  - out_valid and all payload outputs hold while out_ready=0.
  - out_valid never deasserts mid-frame.
- Holdoff counter:
  - Loaded with cfg_holdoff on acceptance of the SOP beat of any XOFF frame.
  - Decrements by 1 per cycle while nonzero; saturates at 0.
  - Cleared to 0 when an XON frame starts.
- xoff_req changes during a frame are not queued individually. On return to IDLE, the current level is compared against adv, so the latest level wins.
- A pulse on xoff_req shorter than one frame that returns to match adv produces no frame.

## Timing
- All outputs are registered. Reset values: out_valid=0, out_data=0, out_error=0, out_startofpacket=0, out_endofpacket=0, out_empty=0, busy=0, frame_sent=0.
- Latency: start condition true in IDLE at cycle N, so out_valid=1 with SOP at cycle N+1.
- Throughput: with out_ready held at 1, a frame takes exactly 8 cycles.
- Back-to-back frames: if a start condition is true when EOP is accepted, the next SOP is driven in the following cycle, with no idle beat.
- Reset mid-frame: outputs clear immediately (asynchronous) and adv=0. After reset release, xoff_req=1 causes a fresh XOFF frame; no partial frame is resumed.
- cfg_enable falling mid-frame: the frame completes; no new frame starts.
- busy=1 from the SOP-valid cycle through the EOP-accept cycle.

## Structure
- Shared package eth_10g_pause_pkg:
  - PAUSE_DA = 48'h0180C2000001.
  - MAC_CTRL_ETYPE = 16'h8808.
  - PAUSE_OPCODE = 16'h0001.
  - PAUSE_BEATS = 8.
  - PAUSE_LAST_EMPTY = 3'd4.
  - State enum {IDLE, SEND}.
- No sub-module. The holdoff counter, beat counter and FSM live in one module.

## Test plan
- Single XOFF: reset release, cfg_pause_quanta=0xFFFF, cfg_src_addr=0x001122334455, cfg_holdoff=0, xoff_req 0→1, out_ready=1 -> 8 beats.
  - beat0 = 0x0180C20000010011; beat1 = 0x2233445588080001; beat2 = 0xFFFF000000000000.
  - EOP on beat7 with empty=4; one frame_sent pulse; no further frames.
- XON: after the XOFF above, xoff_req 1→0 -> one frame with beat2 = 0x0000000000000000.
- Refresh: cfg_holdoff=20 with xoff_req held at 1 -> an XOFF frame every 21 cycles, SOP to SOP, with out_ready=1. Setting cfg_holdoff=0 stops refresh.
- Backpressure: out_ready random at 50% -> beat contents identical to the out_ready=1 run; out_valid never drops mid-frame; payload stable while stalled.
- Coalescing: xoff_req toggles 1→0→1 within a single frame -> no extra frame after it completes. A 1→0 toggle mid-frame -> exactly one XON frame, SOP on the cycle after EOP acceptance.
- Reset mid-frame: assert reset_n=0 at beat 3 -> outputs clear that cycle. Release with xoff_req=1 -> full XOFF frame starting at beat 0.
